banner_rotator: RTL

BANNER_ROTATOR -- requirements
Module: banner_rotator

---
 rtl/banner_pkg.sv | 8 +
 rtl/tick_gen.sv | 27 ++
 rtl/banner_rotator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/banner_pkg.sv
// Shared mode encodings for the banner rotator.
// Reserved encoding 3 behaves as ROTATE.
package banner_pkg;
  localparam logic [1:0] MODE_ROTATE  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;
endpackage

// File: rtl/tick_gen.sv
// Step-rate prescaler: tick is combinational, high on the enabled cycle where count == div.
// A count left above a newly lowered div wraps to 0 without a tick.
module tick_gen #(
  parameter int PRESC_W = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt;

  assign tick = en && !clr && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= div) cnt <= '0;
      else            cnt <= cnt + PRESC_W'(1);
    end
  end
endmodule

// File: rtl/banner_rotator.sv
// Scrolling banner: pos steps on prescaler ticks per mode; window is a registered view lagging pos by one cycle.
// step pulses in the cycle pos shows its new value; load overrides any coincident tick.
module banner_rotator
  import banner_pkg::*;
#(
  parameter int N_SYMB   = 10,
  parameter int N_DIGITS = 8,
  parameter int DIG_W    = 4,
  parameter int PRESC_W  = 27
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        dir,
  input  logic [1:0]                  mode,
  input  logic [PRESC_W-1:0]          step_div,
  input  logic                        load,
  input  logic [N_SYMB*DIG_W-1:0]     banner_in,
  output logic [N_DIGITS*DIG_W-1:0]   window,
  output logic [$clog2(N_SYMB)-1:0]   pos,
  output logic                        step,
  output logic                        done
);
  localparam int POS_W = $clog2(N_SYMB);
  localparam logic [POS_W-1:0] LAST    = POS_W'(N_SYMB - 1);
  localparam logic [POS_W-1:0] END_POS = POS_W'(N_SYMB - N_DIGITS);
  localparam logic [POS_W-1:0] END_M1  = POS_W'(N_SYMB - N_DIGITS - 1);

  logic [N_SYMB*DIG_W-1:0] banner;
  logic                    bdir;
  logic                    tick;

  tick_gen #(.PRESC_W(PRESC_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .div   (step_div),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      banner <= '0;
      pos    <= '0;
      bdir   <= 1'b0;
      done   <= 1'b0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (load) begin
        banner <= banner_in;
        pos    <= '0;
        bdir   <= 1'b0;
        done   <= 1'b0;
      end else if (tick) begin
        case (mode)
          MODE_BOUNCE: begin
            done <= 1'b0;
            step <= 1'b1;
            // Arriving from another mode beyond the bounce range: clamp and head back down.
            if (pos > END_POS) begin
              pos  <= END_POS;
              bdir <= 1'b1;
            end else if (!bdir) begin
              if (pos == END_POS) begin
                pos  <= pos - POS_W'(1);
                bdir <= 1'b1;
              end else begin
                pos <= pos + POS_W'(1);
              end
            end else begin
              if (pos == '0) begin
                pos  <= POS_W'(1);
                bdir <= 1'b0;
              end else begin
                pos <= pos - POS_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            if (!done) begin
              if (pos >= END_POS) begin
                done <= 1'b1;
              end else begin
                pos  <= pos + POS_W'(1);
                step <= 1'b1;
                if (pos == END_M1) done <= 1'b1;
              end
            end
          end
          default: begin
            done <= 1'b0;
            step <= 1'b1;
            if (dir) pos <= (pos == '0)  ? LAST : pos - POS_W'(1);
            else     pos <= (pos == LAST) ? '0  : pos + POS_W'(1);
          end
        endcase
      end
    end
  end

  logic [DIG_W-1:0] sym [N_SYMB];

  for (genvar i = 0; i < N_SYMB; i++) begin : g_sym
    assign sym[i] = banner[i*DIG_W +: DIG_W];
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_win
    localparam logic [POS_W-1:0] OFS   = POS_W'(k);
    localparam logic [POS_W-1:0] SPLIT = POS_W'(N_SYMB - k);
    logic [POS_W-1:0] idx;
    logic [DIG_W-1:0] dig_q;

    // (pos+k) mod N_SYMB without widening: subtract the complement once pos passes the split point.
    assign idx = (pos >= SPLIT) ? pos - SPLIT : pos + OFS;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dig_q <= '0;
      else        dig_q <= sym[idx];
    end

    assign window[k*DIG_W +: DIG_W] = dig_q;
  end
endmodule
